alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised, clocked successor to the execute-stage combinational ALU.
- Single-cycle logic, shift and compare ops complete in 1 cycle; iterative multiply/divide ops complete in XLEN+1 cycles.
- Sits in EX; the pipeline hazard unit stalls on in_ready/out_valid.
- Adds a valid/ready handshake, a flush, and a zero flag that is correct for every op.

Parameters:
- XLEN, 32, operand/result width; any value ≥ 8, power of 2.
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands/op presented
- in_ready  out  1  block can accept this cycle
- a  in  XLEN  operand A (rs1)
- b  in  XLEN  operand B (rs2/imm)
- alu_control  in  4  operation select
- flush  in  1  kill in-flight op (branch mispredict)
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- alu_result  out  XLEN  result
- zero  out  1  alu_result == 0, registered with result
- busy  out  1  iterative op in progress

Behaviour:
- Reset (rst_n low, async): state=IDLE; out_valid=0, alu_result=0, zero=0, busy=0. in_ready=1 after release.
- Accept: transfer on in_valid & in_ready. in_ready = (state==IDLE) & (!out_valid | out_ready), combinational, so a new accept can coincide with a result pop.
- Op encoding:
  - Single-cycle: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0011 XOR, 0100 SLL, 0101 SRL, 1001 SRA, 0111 SLT (signed), 1000 SLTU.
  - Iterative: 1010 MUL (low XLEN), 1011 MULHU (high XLEN, unsigned), 1100 DIV, 1101 DIVU, 1110 REM, 1111 REMU.
- Width and arithmetic rules:
  - ADD/SUB wrap modulo 2^XLEN.
  - Shift amount = b[$clog2(XLEN)-1:0].
  - SLT/SLTU return 0 or 1, zero-extended.
- FSM IDLE -> BUSY -> DONE:
  - Single-cycle op: IDLE -> DONE. Result registered; out_valid=1 the cycle after accept (latency 1).
  - MUL/MULHU: IDLE -> BUSY. Shift-add, 1 bit per cycle, XLEN cycles, then DONE. out_valid asserted XLEN+1 cycles after accept.
  - DIV family: restoring division on magnitudes, 1 bit per cycle, XLEN cycles. Sign fix applied on the BUSY->DONE edge: quotient negated if signs differ; remainder takes the dividend's sign.
  - Divide by zero (b==0): skip BUSY, latency 1. Quotient = all ones; remainder = a.
  - Signed overflow (a = most-negative, b = -1, DIV/REM): skip BUSY, latency 1. Quotient = a; remainder = 0.
  - DONE: hold alu_result/zero/out_valid stable until out_ready, then return to IDLE, or accept the next op in the same cycle.
- busy = (state==BUSY).
- Operands and op are latched at accept; input changes after accept are ignored.
- flush (synchronous, priority over everything except reset):
  - Forces IDLE and out_valid=0 next cycle; discards any partial result.
  - in_ready=0 during the flush cycle.
  - flush with in_valid in the same cycle does not accept.
- Reset mid-BUSY: immediate return to reset values; no partial result is ever presented.
- Unused counter/accumulator bits hold their last value in IDLE; only outputs have defined reset values.

Decomposition:
- Shared package alu_pkg:
  - 4-bit op localparams (ALU_AND … ALU_REMU).
  - State enum (IDLE/BUSY/DONE).
  - Function is_iterative(op).
  - Same constants are used by the ALU-control decoder.
- One sub-module, alu_muldiv_iter: the iterative multiply/divide datapath with start/done, counter, accumulator and sign fix-up.
- Top-level alu_seq holds the combinational ops, FSM, handshake and output registers.

Test Plan:
1. ADD a=0x7FFFFFFF, b=1, out_ready=1 -> next cycle out_valid=1, alu_result=0x80000000, zero=0. SUB a=5, b=5 -> alu_result=0, zero=1.
2. MUL a=0xFFFFFFFF, b=0xFFFFFFFF -> busy high 32 cycles; out_valid at accept+33, alu_result=0x00000001. MULHU same operands -> 0xFFFFFFFE.
3. DIV a=-7, b=2 -> 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1); DIVU a=100, b=7 -> 14, 33 cycles.
4. DIVU a=42, b=0 -> latency 1, alu_result=0xFFFFFFFF. REMU same -> 42. DIV a=0x80000000, b=-1 -> 0x80000000; REM -> 0, zero=1.
5. Backpressure: out_ready=0 for 5 cycles after ADD 3+4 -> alu_result=7 held stable, in_ready=0. Release with in_valid carrying OR 0xF0|0x0F -> both handshakes in one cycle, next result 0xFF.
6. flush at BUSY cycle 10 of DIV -> out_valid never rises for it; next cycle IDLE, in_ready=1. rst_n pulse low mid-MUL -> outputs 0 asynchronously.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU constants: operation encodings, sequencer state and op-class helpers.
// The ALU-control decoder uses the same encodings, so change them only in one place.
package alu_pkg;

  // Single-cycle operations
  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_XOR   = 4'b0011;
  localparam logic [3:0] ALU_SLL   = 4'b0100;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_SLTU  = 4'b1000;
  localparam logic [3:0] ALU_SRA   = 4'b1001;

  // Iterative operations
  localparam logic [3:0] ALU_MUL   = 4'b1010;
  localparam logic [3:0] ALU_MULHU = 4'b1011;
  localparam logic [3:0] ALU_DIV   = 4'b1100;
  localparam logic [3:0] ALU_DIVU  = 4'b1101;
  localparam logic [3:0] ALU_REM   = 4'b1110;
  localparam logic [3:0] ALU_REMU  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // 1010..1111 are the multi-cycle multiply/divide ops.
  function automatic logic is_iterative(input logic [3:0] op);
    return op[3] & (op[2] | op[1]);
  endfunction

  // 1100..1111: the divide family (quotient and remainder, signed and unsigned).
  function automatic logic is_div(input logic [3:0] op);
    return op[3] & op[2];
  endfunction

  function automatic logic is_signed_div(input logic [3:0] op);
    return (op == ALU_DIV) || (op == ALU_REM);
  endfunction

  function automatic logic is_rem(input logic [3:0] op);
    return (op == ALU_REM) || (op == ALU_REMU);
  endfunction

  function automatic logic is_mul_high(input logic [3:0] op);
    return op == ALU_MULHU;
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply/divide datapath: one bit per cycle for XLEN cycles.
// Multiply is unsigned shift-add; divide is restoring division on magnitudes
// with the sign fix-up folded into the final-step result so the top can
// register it on the BUSY->DONE edge. Datapath registers are not reset:
// they are always reloaded by start_i before they matter.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            start_i,   // load operands (accept of an iterative op)
  input  logic            run_i,     // advance one step (sequencer in BUSY)
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            last_o,    // this cycle performs the final step
  output logic [XLEN-1:0] result_o   // sign-fixed result after the current step
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

  // acc: product high half / partial remainder
  // mq : multiplier shifting out, product low half shifting in / dividend->quotient
  logic [XLEN-1:0]  acc_q, acc_d;
  logic [XLEN-1:0]  mq_q, mq_d;
  logic [XLEN-1:0]  mcand_q, mcand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mul_q, mul_d;
  logic             hi_q, hi_d;
  logic             rem_q, rem_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;

  logic [XLEN:0]    mul_sum;
  logic [XLEN:0]    div_shift;
  logic [XLEN:0]    div_diff;
  logic             div_fits;
  logic [XLEN-1:0]  step_acc;
  logic [XLEN-1:0]  step_mq;
  logic             sdiv;
  logic [XLEN-1:0]  abs_a;
  logic [XLEN-1:0]  abs_b;

  // One iteration of whichever algorithm is loaded, plus operand conditioning at start.
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
    div_shift = {acc_q, mq_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, mcand_q};
    div_fits  = ~div_diff[XLEN];
    if (mul_q) begin
      step_acc = mul_sum[XLEN:1];
      step_mq  = {mul_sum[0], mq_q[XLEN-1:1]};
    end else begin
      step_acc = div_fits ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
      step_mq  = {mq_q[XLEN-2:0], div_fits};
    end
    sdiv  = is_signed_div(op_i);
    abs_a = (sdiv && a_i[XLEN-1]) ? (~a_i + 1'b1) : a_i;
    abs_b = (sdiv && b_i[XLEN-1]) ? (~b_i + 1'b1) : b_i;
  end

  // Next-state: load on start, step while running, otherwise hold.
  always_comb begin
    acc_d     = acc_q;
    mq_d      = mq_q;
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
    mul_d     = mul_q;
    hi_d      = hi_q;
    rem_d     = rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    if (start_i) begin
      mul_d     = ~is_div(op_i);
      hi_d      = is_mul_high(op_i);
      rem_d     = is_rem(op_i);
      neg_quo_d = sdiv & (a_i[XLEN-1] ^ b_i[XLEN-1]);
      neg_rem_d = sdiv & a_i[XLEN-1];
      acc_d     = '0;
      cnt_d     = '0;
      if (is_div(op_i)) begin
        mq_d    = abs_a;
        mcand_d = abs_b;
      end else begin
        mq_d    = a_i;
        mcand_d = b_i;
      end
    end else if (run_i) begin
      acc_d = step_acc;
      mq_d  = step_mq;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    acc_q     <= acc_d;
    mq_q      <= mq_d;
    mcand_q   <= mcand_d;
    cnt_q     <= cnt_d;
    mul_q     <= mul_d;
    hi_q      <= hi_d;
    rem_q     <= rem_d;
    neg_quo_q <= neg_quo_d;
    neg_rem_q <= neg_rem_d;
  end

  // Final result from the post-step values: quotient negated when operand
  // signs differ, remainder carries the dividend's sign.
  always_comb begin
    last_o = run_i & (cnt_q == LAST_STEP);
    if (mul_q) begin
      result_o = hi_q ? step_acc : step_mq;
    end else if (rem_q) begin
      result_o = neg_rem_q ? (~step_acc + 1'b1) : step_acc;
    end else begin
      result_o = neg_quo_q ? (~step_mq + 1'b1) : step_mq;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Clocked execute-stage ALU with valid/ready handshake and flush.
// Logic/shift/compare ops (and the divide corner cases) finish in one cycle;
// multiply/divide run XLEN cycles in alu_muldiv_iter.
module alu_seq
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      alu_control,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result,
  output logic            zero,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;

  logic            accept;
  logic            div_by_zero;
  logic            div_ovf;
  logic            special;
  logic            start_iter;
  logic            go_single;
  logic [XLEN-1:0] single_res;
  logic [SHW-1:0]  shamt;
  logic            md_last;
  logic [XLEN-1:0] md_result;

  // Single-cycle results, including the divide-by-zero and signed-overflow shortcuts.
  always_comb begin
    shamt       = b[SHW-1:0];
    div_by_zero = (b == '0);
    div_ovf     = is_signed_div(alu_control) && (a == MOST_NEG) && (b == '1);
    special     = is_div(alu_control) && (div_by_zero || div_ovf);
    single_res  = '0;
    case (alu_control)
      ALU_AND:  single_res = a & b;
      ALU_OR:   single_res = a | b;
      ALU_ADD:  single_res = a + b;
      ALU_SUB:  single_res = a - b;
      ALU_XOR:  single_res = a ^ b;
      ALU_SLL:  single_res = a << shamt;
      ALU_SRL:  single_res = a >> shamt;
      ALU_SRA:  single_res = $unsigned($signed(a) >>> shamt);
      ALU_SLT:  single_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: single_res = {{(XLEN-1){1'b0}}, (a < b)};
      // Only reached when special: b==0 gives all ones, overflow gives a.
      ALU_DIV, ALU_DIVU: single_res = div_by_zero ? '1 : a;
      // b==0 gives a, overflow gives 0.
      ALU_REM, ALU_REMU: single_res = div_by_zero ? a : '0;
      default:  single_res = '0;
    endcase
  end

  // Handshake: a result pop and a new accept may share a cycle; flush blocks accept.
  always_comb begin
    in_ready   = ~flush & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
    busy       = (state_q == BUSY);
    out_valid  = (state_q == DONE);
    alu_result = result_q;
    zero       = zero_q;
  end

  always_comb begin
    accept     = in_valid & in_ready;
    start_iter = accept & is_iterative(alu_control) & ~special;
    go_single  = accept & ~start_iter;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: flush wins; DONE either drains to IDLE or chains straight into the next op.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) state_d = start_iter ? BUSY : DONE;
        end
        BUSY: begin
          if (md_last) state_d = DONE;
        end
        DONE: begin
          if (accept)         state_d = start_iter ? BUSY : DONE;
          else if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Result/zero load: single-cycle ops at accept, iterative ops on their last step.
  always_comb begin
    result_d = result_q;
    zero_d   = zero_q;
    if (!flush) begin
      if (go_single) begin
        result_d = single_res;
        zero_d   = (single_res == '0);
      end else if (md_last) begin
        result_d = md_result;
        zero_d   = (md_result == '0);
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  alu_muldiv_iter #(
    .XLEN (XLEN)
  ) u_muldiv (
    .clk      (clk),
    .start_i  (start_iter),
    .run_i    (busy),
    .op_i     (alu_control),
    .a_i      (a),
    .b_i      (b),
    .last_o   (md_last),
    .result_o (md_result)
  );

endmodule
